// File: rtl/mult_eval_pkg.sv
// Shared types and width constants for the 4x4 multiplier error-evaluation engine.
package mult_eval_pkg;

    localparam int IDX_W       = 8;
    localparam int CNT_W       = 9;
    localparam int SUM_W       = 16;
    localparam int SSUM_W      = 17;
    localparam int MAX_DUT_LAT = 4;
    localparam int NUM_PAIRS   = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mult4_err_accum.sv
// Registered compare of a returned product against the exact product,
// followed by accumulation of the error metrics for every valid tag.
module mult4_err_accum
    import mult_eval_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              in_vld,
    input  logic [3:0]        in_a,
    input  logic [3:0]        in_b,
    input  logic [7:0]        in_prod,
    output logic [CNT_W-1:0]  err_count,
    output logic [SUM_W-1:0]  sum_abs_err,
    output logic [SSUM_W-1:0] sum_err,
    output logic [7:0]        max_abs_err
);

    logic [7:0] exact;
    logic [8:0] err_c;
    logic [8:0] neg_c;
    logic [7:0] abs_c;

    logic       cmp_vld;
    logic       cmp_mis;
    logic [8:0] cmp_err;
    logic [7:0] cmp_abs;

    always_comb begin
        exact = {4'b0000, in_a} * {4'b0000, in_b};
        err_c = {1'b0, in_prod} - {1'b0, exact};
        neg_c = 9'd0 - err_c;
        abs_c = err_c[8] ? neg_c[7:0] : err_c[7:0];
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cmp_vld <= 1'b0;
            cmp_mis <= 1'b0;
            cmp_err <= '0;
            cmp_abs <= '0;
        end else begin
            cmp_vld <= in_vld;
            cmp_mis <= (in_prod != exact);
            cmp_err <= err_c;
            cmp_abs <= abs_c;
        end
    end

    // Sums cannot wrap: 256 pairs of at most 255 fit in 16/17 bits.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            err_count   <= '0;
            sum_abs_err <= '0;
            sum_err     <= '0;
            max_abs_err <= '0;
        end else if (cmp_vld) begin
            err_count   <= err_count + {{(CNT_W-1){1'b0}}, cmp_mis};
            sum_abs_err <= sum_abs_err + {{(SUM_W-8){1'b0}}, cmp_abs};
            sum_err     <= sum_err + {{(SSUM_W-9){cmp_err[8]}}, cmp_err};
            if (cmp_abs > max_abs_err) begin
                max_abs_err <= cmp_abs;
            end
        end
    end

endmodule

// File: rtl/mult4_err_eval.sv
// Sweeps all 256 operand pairs into an attached 4x4 multiplier core and
// accumulates error metrics of the returned products against exact products.
module mult4_err_eval
    import mult_eval_pkg::*;
#(
    parameter int DUT_LAT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [3:0]        op_a,
    output logic [3:0]        op_b,
    input  logic [7:0]        approx_r,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  err_count,
    output logic [SUM_W-1:0]  sum_abs_err,
    output logic [SSUM_W-1:0] sum_err,
    output logic [7:0]        max_abs_err
);

    localparam int DRN_W = $clog2(MAX_DUT_LAT + 1);

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [DRN_W-1:0]   drain_cnt;
    logic               start_acc;
    logic               sweeping;
    logic               last_pair;
    logic               drain_end;
    logic               al_vld;
    logic [IDX_W-1:0]   al_pair;

    assign last_pair = (idx == IDX_W'(NUM_PAIRS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = SWEEP;
            SWEEP:      if (last_pair) state_nxt = DRAIN;
            DRAIN:      if (drain_cnt == '0) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_comb begin
        start_acc = ((state == IDLE) || (state == DONE)) && start;
        sweeping  = (state == SWEEP);
        busy      = (state == SWEEP) || (state == DRAIN);
        drain_end = (state == DRAIN) && (drain_cnt == '0);
    end

    // The index register drives the operands directly; it parks at 255 after a sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (start_acc) begin
            idx <= '0;
        end else if (sweeping && !last_pair) begin
            idx <= idx + IDX_W'(1);
        end
    end

    assign op_a = idx[7:4];
    assign op_b = idx[3:0];

    // DRAIN lasts DUT_LAT+1 cycles: core latency plus compare and accumulate.
    always_ff @(posedge clk) begin
        if (rst) begin
            drain_cnt <= '0;
        end else if (sweeping && last_pair) begin
            drain_cnt <= DRN_W'(DUT_LAT);
        end else if ((state == DRAIN) && (drain_cnt != '0)) begin
            drain_cnt <= drain_cnt - DRN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done <= 1'b0;
        end else begin
            done <= drain_end;
        end
    end

    // Pair k is presented exactly while in SWEEP, so the tag source is the state itself.
    if (DUT_LAT == 0) begin : g_nodly
        assign al_vld  = sweeping;
        assign al_pair = idx;
    end else begin : g_dly
        logic [DUT_LAT-1:0] dly_vld;
        logic [IDX_W-1:0]   dly_pair [DUT_LAT];

        always_ff @(posedge clk) begin
            if (rst) begin
                dly_vld <= '0;
            end else begin
                dly_vld[0] <= sweeping;
                for (int i = 1; i < DUT_LAT; i++) begin
                    dly_vld[i] <= dly_vld[i-1];
                end
            end
        end

        always_ff @(posedge clk) begin
            dly_pair[0] <= idx;
            for (int i = 1; i < DUT_LAT; i++) begin
                dly_pair[i] <= dly_pair[i-1];
            end
        end

        assign al_vld  = dly_vld[DUT_LAT-1];
        assign al_pair = dly_pair[DUT_LAT-1];
    end

    mult4_err_accum u_accum (
        .clk         (clk),
        .rst         (rst),
        .clr         (start_acc),
        .in_vld      (al_vld),
        .in_a        (al_pair[7:4]),
        .in_b        (al_pair[3:0]),
        .in_prod     (approx_r),
        .err_count   (err_count),
        .sum_abs_err (sum_abs_err),
        .sum_err     (sum_err),
        .max_abs_err (max_abs_err)
    );

endmodule

// File: tb/tb_mult4_err_eval.sv
// Bench: two engines (core latency 0 and 2) driven by behavioural core models,
// checked against fixed metric tables and a pair-by-pair reference model.
module tb_mult4_err_eval;

    typedef struct {
        int mode;
        int cnt;
        int sabs;
        int sum;
        int mx;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start0, start2;
    logic [3:0]  op_a0, op_b0, op_a2, op_b2;
    logic [7:0]  approx0, approx2, c1, c2;
    logic        busy0, done0, busy2, done2;
    logic [8:0]  cnt0, cnt2;
    logic [15:0] sabs0, sabs2;
    logic [16:0] sum0, sum2;
    logic [7:0]  mx0, mx2;

    int          mode0, mode2;
    logic [7:0]  rnd_tab [256];
    int          n_cmp = 0;
    int          n_bad = 0;
    vec_t        tab [3];

    always #5 clk = ~clk;

    // mode 0 exact, 1 LSB dropped, 2 stuck at zero, 3 random lookup table
    function automatic logic [7:0] core_f(input int m, input logic [3:0] a, input logic [3:0] b);
        int p;
        p = int'(a) * int'(b);
        case (m)
            0:       return 8'(p);
            1:       return 8'(p) & 8'hFE;
            2:       return 8'h00;
            default: return rnd_tab[{a, b}];
        endcase
    endfunction

    assign approx0 = core_f(mode0, op_a0, op_b0);

    always @(posedge clk) begin
        c1 <= core_f(mode2, op_a2, op_b2);
        c2 <= c1;
    end
    assign approx2 = c2;

    mult4_err_eval #(.DUT_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .op_a(op_a0), .op_b(op_b0),
        .approx_r(approx0), .busy(busy0), .done(done0), .err_count(cnt0),
        .sum_abs_err(sabs0), .sum_err(sum0), .max_abs_err(mx0)
    );

    mult4_err_eval #(.DUT_LAT(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .op_a(op_a2), .op_b(op_b2),
        .approx_r(approx2), .busy(busy2), .done(done2), .err_count(cnt2),
        .sum_abs_err(sabs2), .sum_err(sum2), .max_abs_err(mx2)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic model(input int m, output int cnt, output int sabs, output int s, output int mx);
        int e;
        cnt = 0; sabs = 0; s = 0; mx = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                e = int'(core_f(m, 4'(a), 4'(b))) - a * b;
                if (e != 0) cnt++;
                if (e < 0) e = -e;
                sabs += e;
                s += int'(core_f(m, 4'(a), 4'(b))) - a * b;
                if (e > mx) mx = e;
            end
        end
    endtask

    task automatic chk_metrics(input string tag, input int sel, input int cnt,
                               input int sabs, input int s, input int mx);
        if (sel == 0) begin
            chk({tag, ".l0.err_count"},   int'(cnt0), cnt);
            chk({tag, ".l0.sum_abs_err"}, int'(sabs0), sabs);
            chk({tag, ".l0.sum_err"},     int'($signed(sum0)), s);
            chk({tag, ".l0.max_abs_err"}, int'(mx0), mx);
        end else begin
            chk({tag, ".l2.err_count"},   int'(cnt2), cnt);
            chk({tag, ".l2.sum_abs_err"}, int'(sabs2), sabs);
            chk({tag, ".l2.sum_err"},     int'($signed(sum2)), s);
            chk({tag, ".l2.max_abs_err"}, int'(mx2), mx);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".busy"}, int'(busy0) + int'(busy2), 0);
        chk({tag, ".done"}, int'(done0) + int'(done2), 0);
        chk({tag, ".ops"},  int'({op_a0, op_b0, op_a2, op_b2}), 0);
        chk_metrics(tag, 0, 0, 0, 0, 0);
        chk_metrics(tag, 2, 0, 0, 0, 0);
    endtask

    // Starts both engines together; start is re-pulsed after edge pulse_at (ignored while busy).
    task automatic run_sweep(input int m, input int pulse_at, input string tag);
        int d0, d2, b0, b2;
        mode0 = m;
        mode2 = m;
        @(negedge clk);
        start0 = 1'b1;
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start2 = 1'b0;
        d0 = 0; d2 = 0;
        b0 = int'(busy0);
        b2 = int'(busy2);
        for (int e = 1; e <= 400; e++) begin
            @(posedge clk);
            #1;
            if (busy0) b0++;
            if (busy2) b2++;
            if (done0 && d0 == 0) d0 = e;
            if (done2 && d2 == 0) d2 = e;
            start0 = (e == pulse_at);
            start2 = (e == pulse_at);
            if (d0 != 0 && d2 != 0) break;
        end
        start0 = 1'b0;
        start2 = 1'b0;
        chk({tag, ".l0.done_edge"}, d0, 257);
        chk({tag, ".l2.done_edge"}, d2, 259);
        chk({tag, ".l0.busy_cycles"}, b0, 257);
        chk({tag, ".l2.busy_cycles"}, b2, 259);
        chk({tag, ".final_ops"}, int'({op_a0, op_b0, op_a2, op_b2}), 16'hFFFF);
    endtask

    task automatic wait_done0(input string tag);
        int d;
        d = 0;
        for (int e = 1; e <= 400; e++) begin
            @(posedge clk);
            #1;
            if (done0) begin
                d = e;
                break;
            end
        end
        chk({tag, ".done_edge"}, d, 257);
    endtask

    initial begin
        int c, sa, s, mx;
        tab[0] = '{mode: 0, cnt: 0,   sabs: 0,     sum: 0,      mx: 0};
        tab[1] = '{mode: 1, cnt: 64,  sabs: 64,    sum: -64,    mx: 1};
        tab[2] = '{mode: 2, cnt: 225, sabs: 14400, sum: -14400, mx: 225};

        rst = 1'b1; start0 = 1'b0; start2 = 1'b0; mode0 = 0; mode2 = 0;
        for (int i = 0; i < 256; i++) rnd_tab[i] = 8'($urandom);
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            run_sweep(tab[i].mode, -1, $sformatf("tab%0d", i));
            chk_metrics($sformatf("tab%0d", i), 0, tab[i].cnt, tab[i].sabs, tab[i].sum, tab[i].mx);
            chk_metrics($sformatf("tab%0d", i), 2, tab[i].cnt, tab[i].sabs, tab[i].sum, tab[i].mx);
        end

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 256; i++) rnd_tab[i] = 8'($urandom);
            if (r == 2) for (int i = 0; i < 16; i++) rnd_tab[i * 17] = 8'hFF;
            model(3, c, sa, s, mx);
            run_sweep(3, -1, $sformatf("rnd%0d", r));
            chk_metrics($sformatf("rnd%0d", r), 0, c, sa, s, mx);
            chk_metrics($sformatf("rnd%0d", r), 2, c, sa, s, mx);
        end

        run_sweep(1, 50, "ign_start");
        chk_metrics("ign_start", 0, tab[1].cnt, tab[1].sabs, tab[1].sum, tab[1].mx);
        chk_metrics("ign_start", 2, tab[1].cnt, tab[1].sabs, tab[1].sum, tab[1].mx);

        // reset in the middle of a sweep, then a clean sweep
        mode0 = 2; mode2 = 2;
        @(negedge clk);
        start0 = 1'b1; start2 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0; start2 = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        chk("midsweep.pair", int'({op_a0, op_b0}), 100);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_zero("midreset");
        @(negedge clk);
        rst = 1'b0;
        run_sweep(1, -1, "post_rst");
        chk_metrics("post_rst", 0, tab[1].cnt, tab[1].sabs, tab[1].sum, tab[1].mx);
        chk_metrics("post_rst", 2, tab[1].cnt, tab[1].sabs, tab[1].sum, tab[1].mx);

        // back-to-back: restart in the done cycle with the core switched to stuck-zero
        mode0 = 0;
        @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        wait_done0("b2b_first");
        chk_metrics("b2b_first", 0, tab[0].cnt, tab[0].sabs, tab[0].sum, tab[0].mx);
        mode0 = 2;
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        chk("b2b.accepted_busy", int'(busy0), 1);
        chk("b2b.cleared_count", int'(cnt0), 0);
        wait_done0("b2b_second");
        chk_metrics("b2b_second", 0, tab[2].cnt, tab[2].sabs, tab[2].sum, tab[2].mx);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mult4_err_eval.md
# mult4_err_eval

Self-checking evaluation engine that sits directly downstream of a 4x4 multiplier core, whether exact or approximate. It sweeps all 256 operand pairs into the core and compares each returned 8-bit product against the exact product. It accumulates error metrics (error count, sum of absolute error, signed error sum, maximum absolute error) for on-board characterization of approximate multipliers. Results are held after completion for readout by the host or ILA.

## Interface
- `DUT_LAT`, default 0, meaning: register stages inside the attached multiplier core (0 = combinational core); legal range 0..4.
- `clk`  in  1  single system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a sweep; sampled only in IDLE or DONE.
- `op_a`  out  4  operand A to the multiplier core (registered).
- `op_b`  out  4  operand B to the multiplier core (registered).
- `approx_r`  in  8  product returned by the multiplier core.
- `busy`  out  1  high from start acceptance until done.
- `done`  out  1  one-cycle pulse; metrics are final while high.
- `err_count`  out  9  number of pairs with `approx_r` ≠ exact (0..256).
- `sum_abs_err`  out  16  Σ|approx_r − exact|.
- `sum_err`  out  17  signed two's-complement Σ(approx_r − exact).
- `max_abs_err`  out  8  maximum |approx_r − exact|.

## Operation
- States: IDLE → SWEEP → DRAIN → DONE → (start) SWEEP.
- IDLE/DONE with `start`=1: clear all metrics and the index, load `op_a`/`op_b` = 0/0, go to SWEEP, and set `busy`.
- SWEEP: an 8-bit index k runs 0..255; `op_a`=k[7:4], `op_b`=k[3:0]; k increments every cycle. After pair 255 is issued, go to DRAIN.
- A valid tag plus the {a,b} pair travels through a delay line of depth `DUT_LAT`, so it aligns with `approx_r`.
- Compare stage (registered): exact = a*b (8 bits); err = approx_r − exact as 9-bit signed; abs_err = |err| as 8 bits; mismatch flag.
- Accumulate stage: on a valid tag, update `err_count` += mismatch, `sum_abs_err` += abs_err, `sum_err` += err (sign-extended), and `max_abs_err` = max(`max_abs_err`, abs_err).
- Widths never overflow: max sum_abs is 256×255 = 65280, and sum_err stays within ±65280.
- DRAIN: wait until the last tag has been accumulated, then go to DONE, pulse `done`, and drop `busy`.
- DONE: metrics hold until the next accepted `start`. `op_a`/`op_b` hold at 15/15.
- `start` while `busy`: ignored, with no effect on the index or metrics.
- `rst` (at any time, including mid-sweep): state IDLE; `op_a`, `op_b`, `busy`, `done`, and all metrics return to 0; the delay line valid tags are cleared.

## Timing
- Edge E0 samples `start`=1. After E0, `op_a`/`op_b` present pair 0, and pair k is presented after edge Ek.
- The core output for pair k is sampled by the compare stage at E(k+DUT_LAT+1) and accumulated at E(k+DUT_LAT+2).
- `done` is high for exactly the cycle following E(257+DUT_LAT), and `busy` is low in that cycle. The sweep takes 258+DUT_LAT cycles in total.
- `busy` is high for cycles E0..E(256+DUT_LAT).
- Throughput: one operand pair per cycle, with no stalls.
- A new `start` in the `done` cycle is accepted, and that edge acts as E0 of the new sweep.

## Structure
- Package `mult_eval_pkg` holds the state enum (IDLE, SWEEP, DRAIN, DONE), the width constants (`IDX_W`=8, `CNT_W`=9, `SUM_W`=16, `SSUM_W`=17, `MAX_DUT_LAT`=4), and the total-pair constant 256.
- One sub-module, `mult4_err_accum`: the compare stage plus the accumulate stage, driven by the aligned valid/{a,b}/`approx_r` signals, with a clear input.
- The FSM, index counter and delay line live in the top.

## Test plan
- Exact core (`approx_r`=a*b), `DUT_LAT`=0 → `err_count`=0, `sum_abs_err`=0, `sum_err`=0, `max_abs_err`=0; `done` in the cycle after E257.
- LSB-dropped core (`approx_r`=(a*b)&8'hFE), `DUT_LAT`=0 → `err_count`=64, `sum_abs_err`=64, `sum_err`=−64, `max_abs_err`=1.
- Stuck-zero core (`approx_r`=0) → `err_count`=225, `sum_abs_err`=14400, `sum_err`=−14400, `max_abs_err`=225.
- LSB-dropped core with `DUT_LAT`=2 (two-register model) → same metrics as the `DUT_LAT`=0 case; `done` in the cycle after E259; `busy` high for exactly 259 cycles.
- `rst` asserted at pair 100, then `start` → all outputs 0 during reset; the subsequent sweep gives results identical to a clean run. `start` pulsed at pair 50 of a sweep → ignored, with unchanged metrics and timing.
- Back-to-back sweeps: `start` asserted in the `done` cycle with the core switched from exact to stuck-zero → the second sweep reports 225/14400/−14400/225, with no residue from the first.
